// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - instruction-memory request/grant bundle between the fetch controller and imem
interface fetch_redirect_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC sequencer and imem fetch requester with EX redirect handling
// Optional misaligned-target trap is enabled by defining MISALIGN_TRAP_EN.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_flush,
  input  logic [31:0]                  ex_jump_addr,
  input  logic                         hazard_stall,
  fetch_redirect_ctrl_if.master        imem,
  output logic [31:0]                  pc,
  output logic                         fetch_valid,
  output logic                         if_id_flush,
  output logic                         id_ex_flush,
  output logic                         trap,
  output logic [31:0]                  trap_addr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc;
  logic        take_redirect;

`ifdef MISALIGN_TRAP_EN
  logic [31:0] trap_addr_q, trap_addr_d;
  logic        misaligned;

  assign misaligned  = (ex_jump_addr[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VEC : {ex_jump_addr[31:2], 2'b00};
  assign trap_addr   = trap_addr_q;
`else
  logic unused_cfg;

  // Low target bits are simply dropped; the trap vector has no consumer in this build.
  assign unused_cfg  = ^{ex_jump_addr[1:0], TRAP_VEC};
  assign redirect_pc = {ex_jump_addr[31:2], 2'b00};
  assign trap_addr   = 32'h0000_0000;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem.imem_req = 1'b0;
    fetch_valid   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    take_redirect = 1'b0;
    trap          = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_addr_d   = trap_addr_q;
`endif

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (ex_flush) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          take_redirect = 1'b1;
          pc_d          = redirect_pc;
          state_d       = REDIRECT;
        end else if (!hazard_stall) begin
          // Request stays up until granted; only a stall or flush may drop it.
          imem.imem_req = 1'b1;
          if (imem.imem_gnt) begin
            fetch_valid = 1'b1;
            pc_d        = pc_q + 32'd4;
          end
        end
      end
      REDIRECT: begin
        if (ex_flush) begin
          if_id_flush   = 1'b1;
          take_redirect = 1'b1;
          pc_d          = redirect_pc;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MISALIGN_TRAP_EN
    if (take_redirect && misaligned) begin
      trap        = 1'b1;
      trap_addr_d = ex_jump_addr;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_addr_q <= 32'h0000_0000;
    end else begin
      trap_addr_q <= trap_addr_d;
    end
  end
`endif

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_flush;
  logic [31:0] ex_jump_addr;
  logic        hazard_stall;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        trap;
  logic [31:0] trap_addr;

  fetch_redirect_ctrl_if imem_if ();

  fetch_redirect_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_flush     (ex_flush),
    .ex_jump_addr (ex_jump_addr),
    .hazard_stall (hazard_stall),
    .imem         (imem_if),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .trap         (trap),
    .trap_addr    (trap_addr)
  );

  always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
  localparam logic        EXP_TRAP      = 1'b1;
  localparam logic [31:0] EXP_TRAP_ADDR = 32'h0000_0102;
`else
  localparam logic        EXP_TRAP      = 1'b0;
  localparam logic [31:0] EXP_TRAP_ADDR = 32'h0000_0000;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fetch_q[$];
  logic [2:0]  flush_q[$];
  logic [31:0] exp_addr;
  logic [2:0]  exp_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every granted fetch and every flush/trap strobe must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (fetch_valid) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: actual addr 0x%08h required none", imem_if.imem_addr);
        end else begin
          exp_addr = fetch_q.pop_front();
          chk("fetch_addr", imem_if.imem_addr, exp_addr);
          chk("fetch_req", {31'd0, imem_if.imem_req}, 32'd1);
        end
      end
      if (if_id_flush || id_ex_flush || trap) begin
        if (flush_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flush: actual {if_id,id_ex,trap}=%b required none",
                   {if_id_flush, id_ex_flush, trap});
        end else begin
          exp_flush = flush_q.pop_front();
          chk("flush_strobes", {29'd0, if_id_flush, id_ex_flush, trap}, {29'd0, exp_flush});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b1;
    ex_flush          = 1'b0;
    ex_jump_addr      = 32'h0;
    hazard_stall      = 1'b0;
    imem_if.imem_gnt  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_if.imem_addr, 32'h0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    chk("rst_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_trap_addr", trap_addr, 32'h0);

    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'd0, imem_if.imem_req}, 32'd0);

    fetch_q.push_back(32'h0);
    fetch_q.push_back(32'h4);
    fetch_q.push_back(32'h8);
    next_cycle(); @(negedge clk); chk("run_addr0", imem_if.imem_addr, 32'h0);
    next_cycle(); @(negedge clk); chk("run_addr1", imem_if.imem_addr, 32'h4);
    next_cycle(); @(negedge clk); chk("run_addr2", imem_if.imem_addr, 32'h8);

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      imem_if.imem_gnt = 1'b0;
      @(negedge clk);
      chk("bp_req", {31'd0, imem_if.imem_req}, 32'd1);
      chk("bp_addr", imem_if.imem_addr, 32'hC);
      chk("bp_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    end
    next_cycle();
    imem_if.imem_gnt = 1'b1;
    fetch_q.push_back(32'hC);
    @(negedge clk);

    next_cycle();
    hazard_stall = 1'b1;
    ex_flush     = 1'b1;
    ex_jump_addr = 32'h200;
    flush_q.push_back(3'b110);
    @(negedge clk);
    chk("stflush_req", {31'd0, imem_if.imem_req}, 32'd0);

    next_cycle();
    hazard_stall = 1'b0;
    ex_flush     = 1'b0;
    @(negedge clk);
    chk("redir_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("redir_pc", pc, 32'h200);

    next_cycle();
    fetch_q.push_back(32'h200);
    @(negedge clk);
    chk("redir_fetch_req", {31'd0, imem_if.imem_req}, 32'd1);

    next_cycle();
    ex_flush     = 1'b1;
    ex_jump_addr = 32'h40;
    flush_q.push_back(3'b110);
    @(negedge clk);
    next_cycle();
    ex_jump_addr = 32'h80;
    flush_q.push_back(3'b100);
    @(negedge clk);
    chk("b2b_req", {31'd0, imem_if.imem_req}, 32'd0);
    next_cycle();
    ex_flush = 1'b0;
    @(negedge clk);
    chk("b2b_pc", pc, 32'h80);
    next_cycle();
    fetch_q.push_back(32'h80);
    @(negedge clk);

    next_cycle();
    ex_flush     = 1'b1;
    ex_jump_addr = 32'hFFFF_FFFC;
    flush_q.push_back(3'b110);
    @(negedge clk);
    next_cycle();
    ex_flush = 1'b0;
    @(negedge clk);
    next_cycle();
    fetch_q.push_back(32'hFFFF_FFFC);
    @(negedge clk);
    next_cycle();
    fetch_q.push_back(32'h0);
    @(negedge clk);
    chk("wrap_addr", imem_if.imem_addr, 32'h0);

    next_cycle();
    ex_flush     = 1'b1;
    ex_jump_addr = 32'h102;
    flush_q.push_back({2'b11, EXP_TRAP});
    @(negedge clk);
    chk("mis_trap", {31'd0, trap}, {31'd0, EXP_TRAP});
    next_cycle();
    ex_flush = 1'b0;
    @(negedge clk);
    chk("mis_trap_pulse", {31'd0, trap}, 32'd0);
    chk("mis_trap_addr", trap_addr, EXP_TRAP_ADDR);
    chk("mis_pc", pc, 32'h100);
    next_cycle();
    fetch_q.push_back(32'h100);
    @(negedge clk);

    next_cycle();
    hazard_stall = 1'b1;
    @(negedge clk);
    chk("stall_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("stall_pc", pc, 32'h104);

    next_cycle();
    hazard_stall = 1'b0;
    ex_flush     = 1'b1;
    ex_jump_addr = 32'h300;
    flush_q.push_back(3'b110);
    @(negedge clk);
    next_cycle();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    chk("mid_rst_if_id", {31'd0, if_id_flush}, 32'd0);
    chk("mid_rst_id_ex", {31'd0, id_ex_flush}, 32'd0);
    chk("mid_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("mid_rst_trap_addr", trap_addr, 32'h0);
    ex_flush     = 1'b0;
    hazard_stall = 1'b1;
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_idle_req", {31'd0, imem_if.imem_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rerst_stall_pc", pc, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("fetch_q_empty", fetch_q.size(), 32'd0);
    chk("flush_q_empty", flush_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
